// File: rtl/wb_ic_pkg.sv
// Shared types and default parameters for the Wishbone peripheral interconnect.
package wb_ic_pkg;

  localparam int DEF_NUM_SLAVES       = 27;
  localparam int DEF_ADDR_SEL_LOW_BIT = 16;
  localparam int DEF_ADDR_SEL_BITS    = 6;
  localparam int DEF_TIMEOUT_CYCLES   = 255;

  localparam int WB_ADDR_W     = 32;
  localparam int WB_DATA_W     = 32;
  localparam int WB_SEL_W      = 4;
  localparam int TIMEOUT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } ic_state_t;

endpackage

// File: rtl/wb_ic_timeout.sv
// Loadable saturating stall counter; expired is high while the count sits at LIMIT.
module wb_ic_timeout #(
  parameter int WIDTH = 16,
  parameter int LIMIT = 254
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  assign expired = (count == WIDTH'(LIMIT));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wb_periph_interconnect.sv
// Single-master Wishbone interconnect: decodes an address slot, forwards one
// registered request to that slave, and returns a registered ack/err.
module wb_periph_interconnect
  import wb_ic_pkg::*;
#(
  parameter int NUM_SLAVES       = DEF_NUM_SLAVES,
  parameter int ADDR_SEL_LOW_BIT = DEF_ADDR_SEL_LOW_BIT,
  parameter int ADDR_SEL_BITS    = DEF_ADDR_SEL_BITS,
  parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic                            m_wb_cyc_i,
  input  logic                            m_wb_stb_i,
  input  logic                            m_wb_we_i,
  input  logic [WB_ADDR_W-1:0]            m_wb_adr_i,
  input  logic [WB_DATA_W-1:0]            m_wb_dat_i,
  input  logic [WB_SEL_W-1:0]             m_wb_sel_i,
  output logic [WB_DATA_W-1:0]            m_wb_dat_o,
  output logic                            m_wb_ack_o,
  output logic                            m_wb_err_o,
  output logic [NUM_SLAVES-1:0]           s_wb_cyc_o,
  output logic [NUM_SLAVES-1:0]           s_wb_stb_o,
  output logic [NUM_SLAVES-1:0]           s_wb_we_o,
  output logic [NUM_SLAVES*WB_ADDR_W-1:0] s_wb_adr_o,
  output logic [NUM_SLAVES*WB_DATA_W-1:0] s_wb_dat_o,
  output logic [NUM_SLAVES*WB_SEL_W-1:0]  s_wb_sel_o,
  input  logic [NUM_SLAVES*WB_DATA_W-1:0] s_wb_dat_i,
  input  logic [NUM_SLAVES-1:0]           s_wb_ack_i,
  input  logic [NUM_SLAVES-1:0]           s_wb_err_i,
  output logic                            timeout_o,
  output logic [ADDR_SEL_BITS-1:0]        err_slot_o
);

  localparam logic [ADDR_SEL_BITS:0] NUM_SLAVES_W = (ADDR_SEL_BITS+1)'(NUM_SLAVES);

  ic_state_t                state;
  logic [WB_ADDR_W-1:0]     adr_q;
  logic [WB_DATA_W-1:0]     dat_q;
  logic [WB_SEL_W-1:0]      sel_q;
  logic                     we_q;
  logic [ADDR_SEL_BITS-1:0] slot_q;
  logic                     resp_err_q;

  logic [ADDR_SEL_BITS-1:0] req_idx;
  logic                     req_mapped;
  logic                     req_valid;
  logic                     slv_ack;
  logic                     slv_err;
  logic [WB_DATA_W-1:0]     slv_dat;
  logic                     expired;

  assign req_idx    = m_wb_adr_i[ADDR_SEL_LOW_BIT +: ADDR_SEL_BITS];
  assign req_mapped = ({1'b0, req_idx} < NUM_SLAVES_W);
  // A response still on the bus blocks acceptance so a master that holds stb
  // until it samples ack is not counted twice.
  assign req_valid  = m_wb_cyc_i && m_wb_stb_i && !m_wb_ack_o && !m_wb_err_o;

  always_comb begin
    s_wb_cyc_o = '0;
    s_wb_stb_o = '0;
    s_wb_we_o  = '0;
    s_wb_adr_o = '0;
    s_wb_dat_o = '0;
    s_wb_sel_o = '0;
    slv_ack    = 1'b0;
    slv_err    = 1'b0;
    slv_dat    = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (state == BUSY && slot_q == ADDR_SEL_BITS'(i)) begin
        s_wb_cyc_o[i]                      = 1'b1;
        s_wb_stb_o[i]                      = 1'b1;
        s_wb_we_o[i]                       = we_q;
        s_wb_adr_o[i*WB_ADDR_W +: WB_ADDR_W] = adr_q;
        s_wb_dat_o[i*WB_DATA_W +: WB_DATA_W] = dat_q;
        s_wb_sel_o[i*WB_SEL_W +: WB_SEL_W]   = sel_q;
        slv_ack = s_wb_ack_i[i];
        slv_err = s_wb_err_i[i];
        slv_dat = s_wb_dat_i[i*WB_DATA_W +: WB_DATA_W];
      end
    end
  end

  wb_ic_timeout #(
    .WIDTH (TIMEOUT_CNT_W),
    .LIMIT (TIMEOUT_CYCLES - 1)
  ) u_timeout (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .clear      (state != BUSY),
    .load       (1'b0),
    .load_value ('0),
    .enable     ((state == BUSY) && !slv_ack && !slv_err),
    .expired    (expired)
  );

  // Every error path zeroes the returned data; ack loads the slave data.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      slot_q     <= '0;
      resp_err_q <= 1'b0;
      m_wb_dat_o <= '0;
      m_wb_ack_o <= 1'b0;
      m_wb_err_o <= 1'b0;
      timeout_o  <= 1'b0;
      err_slot_o <= '0;
    end else begin
      m_wb_ack_o <= 1'b0;
      m_wb_err_o <= 1'b0;
      timeout_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            adr_q  <= m_wb_adr_i;
            dat_q  <= m_wb_dat_i;
            sel_q  <= m_wb_sel_i;
            we_q   <= m_wb_we_i;
            slot_q <= req_idx;
            if (req_mapped) begin
              state <= BUSY;
            end else begin
              state      <= RESP;
              resp_err_q <= 1'b1;
              m_wb_dat_o <= '0;
              err_slot_o <= req_idx;
            end
          end
        end
        BUSY: begin
          if (!m_wb_cyc_i) begin
            state <= IDLE;
          end else if (slv_err) begin
            state      <= RESP;
            resp_err_q <= 1'b1;
            m_wb_dat_o <= '0;
            err_slot_o <= slot_q;
          end else if (slv_ack) begin
            state      <= RESP;
            resp_err_q <= 1'b0;
            m_wb_dat_o <= slv_dat;
          end else if (expired) begin
            state      <= RESP;
            resp_err_q <= 1'b1;
            m_wb_dat_o <= '0;
            err_slot_o <= slot_q;
            timeout_o  <= 1'b1;
          end
        end
        RESP: begin
          m_wb_ack_o <= !resp_err_q;
          m_wb_err_o <= resp_err_q;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_periph_interconnect.sv
// Directed self-checking bench for wb_periph_interconnect (27 slots, 8-cycle timeout).
module tb_wb_periph_interconnect;

  localparam int NS = 27;
  localparam int SB = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              m_cyc, m_stb, m_we;
  logic [31:0]       m_adr, m_dat_w;
  logic [3:0]        m_sel;
  logic [31:0]       m_dat_r;
  logic              m_ack, m_err;
  logic [NS-1:0]     s_cyc, s_stb, s_we;
  logic [NS*32-1:0]  s_adr, s_dat_w;
  logic [NS*4-1:0]   s_sel;
  logic [NS*32-1:0]  s_dat_r;
  logic [NS-1:0]     s_ack, s_err;
  logic              timeout;
  logic [SB-1:0]     err_slot;

  int          checks = 0;
  int          fails  = 0;
  int          slv_slot = 0;
  logic        slv_ack = 1'b0;
  logic        slv_err = 1'b0;
  logic [31:0] slv_data = '0;

  wb_periph_interconnect #(
    .NUM_SLAVES       (NS),
    .ADDR_SEL_LOW_BIT (16),
    .ADDR_SEL_BITS    (SB),
    .TIMEOUT_CYCLES   (8)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .m_wb_cyc_i (m_cyc),
    .m_wb_stb_i (m_stb),
    .m_wb_we_i  (m_we),
    .m_wb_adr_i (m_adr),
    .m_wb_dat_i (m_dat_w),
    .m_wb_sel_i (m_sel),
    .m_wb_dat_o (m_dat_r),
    .m_wb_ack_o (m_ack),
    .m_wb_err_o (m_err),
    .s_wb_cyc_o (s_cyc),
    .s_wb_stb_o (s_stb),
    .s_wb_we_o  (s_we),
    .s_wb_adr_o (s_adr),
    .s_wb_dat_o (s_dat_w),
    .s_wb_sel_o (s_sel),
    .s_wb_dat_i (s_dat_r),
    .s_wb_ack_i (s_ack),
    .s_wb_err_i (s_err),
    .timeout_o  (timeout),
    .err_slot_o (err_slot)
  );

  always #5 clk = ~clk;

  // Zero-wait slave behaviour for the one slot under test.
  always_comb begin
    s_ack   = '0;
    s_err   = '0;
    s_dat_r = '0;
    if (s_cyc[slv_slot] && s_stb[slv_slot]) begin
      s_ack[slv_slot]              = slv_ack;
      s_err[slv_slot]              = slv_err;
      s_dat_r[slv_slot*32 +: 32]   = slv_data;
    end
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_req(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_dat_w = dat; m_sel = 4'hF;
  endtask

  task automatic end_req();
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; end_req(); m_adr = '0; m_dat_w = '0; m_sel = '0;
    tick(3);
    checks++;
    if ({s_cyc, s_stb, s_we} !== '0) begin
      fails++; $display("[TB] FAIL reset_slave_ctl: got %h required 0", {s_cyc, s_stb, s_we});
    end
    checks++;
    if ({m_ack, m_err, timeout} !== 3'b000) begin
      fails++; $display("[TB] FAIL reset_resp: got %b required 000", {m_ack, m_err, timeout});
    end
    checks++;
    if (m_dat_r !== 32'h0 || err_slot !== '0) begin
      fails++; $display("[TB] FAIL reset_data: dat %h err_slot %0d required 0/0", m_dat_r, err_slot);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_read();
    slv_slot = 3; slv_ack = 1'b1; slv_err = 1'b0; slv_data = 32'h1234_5678;
    start_req(1'b0, 32'h0003_0010, 32'h0);
    tick(1);
    checks++;
    if (s_cyc !== (NS'(1) << 3) || s_stb !== (NS'(1) << 3)) begin
      fails++; $display("[TB] FAIL read_strobe: cyc %h stb %h required %h", s_cyc, s_stb, NS'(1) << 3);
    end
    checks++;
    if (s_adr[3*32 +: 32] !== 32'h0003_0010 || s_sel[3*4 +: 4] !== 4'hF || s_we[3] !== 1'b0) begin
      fails++; $display("[TB] FAIL read_fwd: adr %h sel %h we %b required 00030010/f/0", s_adr[3*32 +: 32], s_sel[3*4 +: 4], s_we[3]);
    end
    tick(1);
    checks++;
    if (s_cyc !== '0 || m_ack !== 1'b0) begin
      fails++; $display("[TB] FAIL read_cycle2: cyc %h ack %b required 0/0", s_cyc, m_ack);
    end
    tick(1);
    checks++;
    if (m_ack !== 1'b1 || m_err !== 1'b0 || m_dat_r !== 32'h1234_5678) begin
      fails++; $display("[TB] FAIL read_ack: ack %b err %b dat %h required 1/0/12345678", m_ack, m_err, m_dat_r);
    end
    end_req();
    tick(1);
    checks++;
    if (m_ack !== 1'b0 || m_dat_r !== 32'h1234_5678) begin
      fails++; $display("[TB] FAIL read_hold: ack %b dat %h required 0/12345678", m_ack, m_dat_r);
    end
    slv_ack = 1'b0;
  endtask

  task automatic test_ack_err();
    slv_slot = 7; slv_ack = 1'b1; slv_err = 1'b1; slv_data = 32'hFFFF_0000;
    start_req(1'b1, 32'h0007_0100, 32'hCAFE_F00D);
    tick(1);
    checks++;
    if (s_dat_w[7*32 +: 32] !== 32'hCAFE_F00D || s_we[7] !== 1'b1) begin
      fails++; $display("[TB] FAIL wr_fwd: dat %h we %b required cafef00d/1", s_dat_w[7*32 +: 32], s_we[7]);
    end
    tick(2);
    checks++;
    if (m_err !== 1'b1 || m_ack !== 1'b0 || m_dat_r !== 32'h0 || err_slot !== SB'(7)) begin
      fails++; $display("[TB] FAIL ack_err: err %b ack %b dat %h slot %0d required 1/0/0/7", m_err, m_ack, m_dat_r, err_slot);
    end
    end_req();
    slv_ack = 1'b0; slv_err = 1'b0;
    tick(1);
  endtask

  task automatic test_unmapped();
    start_req(1'b1, 32'h001B_0000, 32'h5555_AAAA);
    tick(1);
    checks++;
    if (s_cyc !== '0 || s_stb !== '0 || m_err !== 1'b0) begin
      fails++; $display("[TB] FAIL unmapped_c1: cyc %h stb %h err %b required 0/0/0", s_cyc, s_stb, m_err);
    end
    tick(1);
    checks++;
    if (m_err !== 1'b1 || m_ack !== 1'b0 || err_slot !== SB'(27) || s_stb !== '0) begin
      fails++; $display("[TB] FAIL unmapped_err: err %b ack %b slot %0d stb %h required 1/0/27/0", m_err, m_ack, err_slot, s_stb);
    end
    end_req();
    tick(1);
    checks++;
    if (m_err !== 1'b0) begin
      fails++; $display("[TB] FAIL unmapped_pulse: err %b required 0", m_err);
    end
  endtask

  task automatic test_timeout();
    int stall_bad;
    stall_bad = 0;
    slv_slot = 5; slv_ack = 1'b0; slv_err = 1'b0;
    start_req(1'b0, 32'h0005_0000, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      tick(1);
      if (s_cyc[5] !== 1'b1 || timeout !== 1'b0 || m_err !== 1'b0) stall_bad++;
    end
    checks++;
    if (stall_bad !== 0) begin
      fails++; $display("[TB] FAIL timeout_stall: %0d bad stall cycles required 0", stall_bad);
    end
    tick(1);
    checks++;
    if (timeout !== 1'b1 || s_cyc !== '0 || m_err !== 1'b0) begin
      fails++; $display("[TB] FAIL timeout_pulse: to %b cyc %h err %b required 1/0/0", timeout, s_cyc, m_err);
    end
    tick(1);
    checks++;
    if (timeout !== 1'b0 || m_err !== 1'b1 || m_ack !== 1'b0 || err_slot !== SB'(5)) begin
      fails++; $display("[TB] FAIL timeout_err: to %b err %b ack %b slot %0d required 0/1/0/5", timeout, m_err, m_ack, err_slot);
    end
    end_req();
    tick(1);
  endtask

  task automatic test_ack_at_limit();
    slv_slot = 5; slv_ack = 1'b0; slv_err = 1'b0; slv_data = 32'h600D_F00D;
    start_req(1'b0, 32'h0005_0040, 32'h0);
    tick(8);
    slv_ack = 1'b1;
    tick(1);
    checks++;
    if (timeout !== 1'b0 || s_cyc !== '0) begin
      fails++; $display("[TB] FAIL limit_no_timeout: to %b cyc %h required 0/0", timeout, s_cyc);
    end
    tick(1);
    checks++;
    if (m_ack !== 1'b1 || m_err !== 1'b0 || m_dat_r !== 32'h600D_F00D) begin
      fails++; $display("[TB] FAIL limit_ack: ack %b err %b dat %h required 1/0/600df00d", m_ack, m_err, m_dat_r);
    end
    end_req();
    slv_ack = 1'b0;
    tick(1);
  endtask

  task automatic test_stb_no_cyc();
    int seen;
    seen = 0;
    slv_slot = 3; slv_ack = 1'b1;
    m_cyc = 1'b0; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h0003_0000;
    for (int c = 0; c < 4; c++) begin
      tick(1);
      if (s_stb !== '0 || m_ack !== 1'b0 || m_err !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      fails++; $display("[TB] FAIL stb_no_cyc: %0d active cycles required 0", seen);
    end
    end_req();
    slv_ack = 1'b0;
  endtask

  task automatic test_abort_and_reset();
    int resp_seen;
    resp_seen = 0;
    slv_slot = 2; slv_ack = 1'b0;
    start_req(1'b0, 32'h0002_0000, 32'h0);
    tick(2);
    end_req();
    tick(1);
    checks++;
    if (s_cyc !== '0 || s_stb !== '0) begin
      fails++; $display("[TB] FAIL abort_drop: cyc %h stb %h required 0/0", s_cyc, s_stb);
    end
    for (int c = 0; c < 12; c++) begin
      if (m_ack !== 1'b0 || m_err !== 1'b0 || timeout !== 1'b0) resp_seen++;
      tick(1);
    end
    checks++;
    if (resp_seen !== 0) begin
      fails++; $display("[TB] FAIL abort_noresp: %0d response cycles required 0", resp_seen);
    end
    slv_slot = 4;
    start_req(1'b1, 32'h0004_0008, 32'h1111_2222);
    tick(2);
    rst = 1'b1;
    tick(1);
    end_req();
    checks++;
    if (s_cyc !== '0 || m_ack !== 1'b0 || m_err !== 1'b0 || err_slot !== '0 || m_dat_r !== 32'h0) begin
      fails++; $display("[TB] FAIL midreset: cyc %h ack %b err %b slot %0d dat %h required all 0", s_cyc, m_ack, m_err, err_slot, m_dat_r);
    end
    rst = 1'b0;
    tick(2);
    slv_slot = 0; slv_ack = 1'b1; slv_data = 32'hA5A5_0F0F;
    start_req(1'b0, 32'h0000_0004, 32'h0);
    tick(1);
    checks++;
    if (s_cyc !== NS'(1)) begin
      fails++; $display("[TB] FAIL post_reset_strobe: cyc %h required %h", s_cyc, NS'(1));
    end
    tick(2);
    checks++;
    if (m_ack !== 1'b1 || m_err !== 1'b0 || m_dat_r !== 32'hA5A5_0F0F) begin
      fails++; $display("[TB] FAIL post_reset_ack: ack %b err %b dat %h required 1/0/a5a50f0f", m_ack, m_err, m_dat_r);
    end
    end_req();
    slv_ack = 1'b0;
    tick(1);
  endtask

  initial begin
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_adr = '0; m_dat_w = '0; m_sel = '0; rst = 1'b1;
    test_reset();
    test_read();
    test_ack_err();
    test_unmapped();
    test_timeout();
    test_ack_at_limit();
    test_stb_no_cyc();
    test_abort_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
